// File: rtl/deshuffle_seq_if.sv
// rtl/deshuffle_seq_if.sv - group-in / frame-out handshake bundle for deshuffle_seq
interface deshuffle_seq_if #(
    parameter int WAY  = 2,
    parameter int WIRE = 4
);
    localparam int SIZE = WAY * WIRE;

    logic            in_valid;
    logic            in_ready;
    logic [WAY-1:0]  in_data;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] out_data;
    logic            out_err;

    // Producer of groups and consumer of frames
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    // The de-interleaver itself
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/deshuffle_seq.sv
// rtl/deshuffle_seq.sv - reassembles WIRE serial WAY-bit groups into one un-shuffled frame
module deshuffle_seq #(
    parameter int WAY  = 2,
    parameter int WIRE = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    deshuffle_seq_if.slave bus
);
    localparam int SIZE = WAY * WIRE;
    localparam int CW   = (WIRE > 1) ? $clog2(WIRE) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIRE - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SIZE-1:0] acc_q, acc_d;
    logic [SIZE-1:0] out_q, out_d;
    logic            err_q, err_d;
    logic [SIZE-1:0] merged;
    logic            in_ready_w;
    logic            out_valid_w;
    logic            xfer;
    logic            at_end;
    logic            close;

    assign xfer   = bus.in_valid & in_ready_w;
    assign at_end = (cnt_q == LAST_IDX);
    assign close  = xfer & (bus.in_last | at_end);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a closing group always lands in HOLD; a consumed frame otherwise returns to FILL
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                if (close) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = close ? HOLD : FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Handshake outputs: accept while filling, or while the held frame is being taken
    always_comb begin
        in_ready_w  = (state_q == FILL) | bus.out_ready;
        out_valid_w = (state_q == HOLD);
    end

    // Frame under construction with the incoming group folded in; group 0 starts from a clean frame
    always_comb begin
        merged = (cnt_q == '0) ? '0 : acc_q;
        for (int k = 0; k < WAY; k++) begin
            for (int w = 0; w < WIRE; w++) begin
                if (w == int'(cnt_q)) begin
                    merged[k*WIRE + w] = bus.in_data[k];
                end
            end
        end
    end

    // Next-state datapath: the presented frame and error only move on a closing group
    always_comb begin
        acc_d = xfer ? merged : acc_q;
        out_d = close ? merged : out_q;
        err_d = close ? (bus.in_last != at_end) : err_q;
        cnt_d = cnt_q;
        if (xfer) begin
            cnt_d = close ? '0 : cnt_q + CW'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            acc_q <= '0;
            out_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            out_q <= out_d;
            err_q <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = out_q;
    assign bus.out_err   = err_q;
endmodule
